// File: rtl/gps_log_ctrl_pkg.sv
// Shared types and defaults for the GPS IQ capture sequencer.
package gps_log_ctrl_pkg;

    localparam int unsigned DEPTH_LOG2_DEF = 10;
    localparam int unsigned DECIM_W_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // Code 3 is reserved and behaves like TRIG_IMM.
    typedef enum logic [1:0] {
        TRIG_IMM   = 2'd0,
        TRIG_EPOCH = 2'd1,
        TRIG_EXT   = 2'd2,
        TRIG_RSVD  = 2'd3
    } trig_e;

endpackage

// File: rtl/gps_log_ctrl_if.sv
// Host, sample-tap and logger-port signals of the capture sequencer.
interface gps_log_ctrl_if
    import gps_log_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned DECIM_W    = DECIM_W_DEF
);
    logic                  cmd_arm;
    logic                  cmd_abort;
    logic                  cfg_src;
    logic [1:0]            cfg_trig;
    logic [DECIM_W-1:0]    cfg_decim;
    logic [DEPTH_LOG2-1:0] cfg_len;
    logic                  s0_vld;
    logic                  s1_vld;
    logic [15:0]           s0_iq;
    logic [15:0]           s1_iq;
    logic                  epoch;
    logic                  ext_trig;
    logic                  log_rst;
    logic                  log_wr;
    logic [15:0]           log_din;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2:0]   word_cnt;

    modport master (
        output cmd_arm, cmd_abort, cfg_src, cfg_trig, cfg_decim, cfg_len,
               s0_vld, s1_vld, s0_iq, s1_iq, epoch, ext_trig,
        input  log_rst, log_wr, log_din, busy, done, word_cnt
    );

    modport slave (
        input  cmd_arm, cmd_abort, cfg_src, cfg_trig, cfg_decim, cfg_len,
               s0_vld, s1_vld, s0_iq, s1_iq, epoch, ext_trig,
        output log_rst, log_wr, log_din, busy, done, word_cnt
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/gps_log_ctrl.sv
// Capture sequencer: arm, clear logger pointers, wait for trigger, stream decimated
// samples from the selected IQ tap into the logger until the programmed length.
module gps_log_ctrl
    import gps_log_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned DECIM_W    = DECIM_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    gps_log_ctrl_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] WC_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_e                state_q, state_d;
    logic                  src_q;
    trig_e                 trig_q;
    logic [DECIM_W-1:0]    decim_q, dcnt_q;
    logic [DEPTH_LOG2-1:0] len_q;
    logic [DEPTH_LOG2:0]   word_cnt_q;
    logic                  log_wr_q;
    logic [15:0]           log_din_q;

    logic        ext_rise, trig_hit, arm_ok, abort_ok, full, sel_vld, cap_vld, wr_en;
    logic [15:0] sel_iq;

    sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.ext_trig),
        .rise_o (ext_rise)
    );

    // Abort outranks every other event; full blocks writes so word_cnt cannot overrun.
    always_comb begin
        abort_ok = bus.cmd_abort && (state_q != ST_IDLE);
        arm_ok   = bus.cmd_arm && !abort_ok && (state_q == ST_IDLE || state_q == ST_DONE);
        full     = (word_cnt_q == ({1'b0, len_q} + 1'b1));
        sel_vld  = src_q ? bus.s1_vld : bus.s0_vld;
        sel_iq   = src_q ? bus.s1_iq  : bus.s0_iq;
        cap_vld  = (state_q == ST_CAPTURE) && sel_vld && !full && !abort_ok;
        wr_en    = cap_vld && (dcnt_q == '0);
        case (trig_q)
            TRIG_EPOCH: trig_hit = bus.epoch;
            TRIG_EXT:   trig_hit = ext_rise;
            default:    trig_hit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm_ok) state_d = ST_CLEAR;
                ST_CLEAR:         state_d = ST_WAIT_TRIG;
                ST_WAIT_TRIG:     if (trig_hit) state_d = ST_CAPTURE;
                ST_CAPTURE:       if (full) state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.log_rst  = (state_q == ST_CLEAR);
        bus.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus.done     = (state_q == ST_DONE);
        bus.log_wr   = log_wr_q;
        bus.log_din  = log_din_q;
        bus.word_cnt = word_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= 1'b0;
            trig_q     <= TRIG_IMM;
            decim_q    <= '0;
            len_q      <= '0;
            dcnt_q     <= '0;
            word_cnt_q <= '0;
            log_wr_q   <= 1'b0;
            log_din_q  <= '0;
        end else begin
            log_wr_q <= wr_en;
            if (arm_ok) begin
                src_q      <= bus.cfg_src;
                trig_q     <= trig_e'(bus.cfg_trig);
                decim_q    <= bus.cfg_decim;
                len_q      <= bus.cfg_len;
                word_cnt_q <= '0;
            end else if (wr_en && word_cnt_q != WC_MAX) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (wr_en) log_din_q <= sel_iq;
            if (state_q == ST_WAIT_TRIG && trig_hit && !abort_ok) begin
                dcnt_q <= '0;
            end else if (cap_vld) begin
                dcnt_q <= (dcnt_q == '0) ? decim_q : dcnt_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gps_log_ctrl.sv
// Directed bench for gps_log_ctrl: vector table for a basic capture plus hand-written sequences.
module tb_gps_log_ctrl;
    import gps_log_ctrl_pkg::*;

    localparam int unsigned DL = 10;
    localparam int unsigned DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gps_log_ctrl_if #(.DEPTH_LOG2(DL), .DECIM_W(DW)) bus ();

    gps_log_ctrl #(.DEPTH_LOG2(DL), .DECIM_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        arm;
        logic        vld;
        logic [15:0] iq;
        logic        e_rst;
        logic        e_wr;
        logic [15:0] e_din;
        logic        e_busy;
        logic        e_done;
        logic [10:0] e_wc;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [31:0] obs();
        return {1'b0, bus.log_rst, bus.log_wr, bus.log_din, bus.busy, bus.done, bus.word_cnt};
    endfunction

    function automatic logic [31:0] expv(input logic r, input logic w, input logic [15:0] d,
                                         input logic b, input logic dn, input logic [10:0] wc);
        return {1'b0, r, w, d, b, dn, wc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cfg(input logic src, input logic [1:0] trig, input logic [3:0] decim,
                           input logic [9:0] len);
        bus.cfg_src   = src;
        bus.cfg_trig  = trig;
        bus.cfg_decim = decim;
        bus.cfg_len   = len;
        bus.cmd_arm   = 1'b1;
        tick();
        bus.cmd_arm   = 1'b0;
    endtask

    initial begin
        int nw;
        int bad;
        bus.cmd_arm = 0; bus.cmd_abort = 0; bus.cfg_src = 0; bus.cfg_trig = 0;
        bus.cfg_decim = 0; bus.cfg_len = 0; bus.s0_vld = 0; bus.s1_vld = 0;
        bus.s0_iq = 0; bus.s1_iq = 0; bus.epoch = 0; bus.ext_trig = 0;

        #2;
        chk("reset_outputs", obs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture: trig imm, decim 0, len 3, s0 valid for 8 cycles
        tbl[0]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 11'd0};
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 11'd0};
        tbl[2]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 11'd0};
        tbl[3]  = '{0, 1, 16'h0100, 0, 1, 16'h0100, 1, 0, 11'd1};
        tbl[4]  = '{0, 1, 16'h0101, 0, 1, 16'h0101, 1, 0, 11'd2};
        tbl[5]  = '{0, 1, 16'h0102, 0, 1, 16'h0102, 1, 0, 11'd3};
        tbl[6]  = '{0, 1, 16'h0103, 0, 1, 16'h0103, 1, 0, 11'd4};
        tbl[7]  = '{0, 1, 16'h0104, 0, 0, 16'h0103, 0, 1, 11'd4};
        tbl[8]  = '{0, 1, 16'h0105, 0, 0, 16'h0103, 0, 1, 11'd4};
        tbl[9]  = '{0, 1, 16'h0106, 0, 0, 16'h0103, 0, 1, 11'd4};
        tbl[10] = '{0, 1, 16'h0107, 0, 0, 16'h0103, 0, 1, 11'd4};
        bus.cfg_src = 0; bus.cfg_trig = 0; bus.cfg_decim = 0; bus.cfg_len = 10'd3;
        for (int i = 0; i < 11; i++) begin
            bus.cmd_arm = tbl[i].arm;
            bus.s0_vld  = tbl[i].vld;
            bus.s0_iq   = tbl[i].iq;
            tick();
            chk($sformatf("vec%0d", i), obs(),
                expv(tbl[i].e_rst, tbl[i].e_wr, tbl[i].e_din, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_wc));
        end
        bus.cmd_arm = 0; bus.s0_vld = 0;

        // Epoch trigger, decim 2, source 1, s0 noise; config changes after arm are shadowed
        arm_cfg(1'b1, 2'd1, 4'd2, 10'd3);
        chk("t2_log_rst", {31'b0, bus.log_rst}, 32'd1);
        bus.cfg_src = 0; bus.cfg_decim = 0; bus.cfg_len = 10'd100;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.s1_vld = 1; bus.s1_iq = 16'h1F00 + 16'(i);
            bus.s0_vld = 1; bus.s0_iq = 16'h5A00 + 16'(i);
            tick();
            chk("t2_prewait", {30'b0, bus.log_wr, bus.busy}, 32'd1);
        end
        bus.epoch = 1;
        tick();
        bus.epoch = 0;
        chk("t2_trig_sample", {31'b0, bus.log_wr}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            logic ew;
            ew = (i % 3 == 0) && (i <= 9);
            bus.s1_iq = 16'h2000 + 16'(i);
            bus.s0_iq = 16'h5A00 + 16'(i);
            tick();
            chk($sformatf("t2_wr%0d", i), {31'b0, bus.log_wr}, {31'b0, ew});
            if (ew) chk($sformatf("t2_din%0d", i), {16'b0, bus.log_din}, {16'b0, 16'h2000 + 16'(i)});
        end
        chk("t2_end", {20'b0, bus.busy, bus.done, bus.word_cnt}, {20'b0, 1'b0, 1'b1, 11'd4});
        bus.s0_vld = 0; bus.s1_vld = 0;

        // External trigger: 3-cycle latency, held-high does not retrigger
        arm_cfg(1'b0, 2'd2, 4'd0, 10'd0);
        tick();
        bus.s0_vld = 1; bus.s0_iq = 16'h7777;
        #2 bus.ext_trig = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t3_lat%0d", k), {31'b0, bus.log_wr}, {31'b0, k == 4});
        end
        tick();
        chk("t3_done", {31'b0, bus.done}, 32'd1);
        arm_cfg(1'b0, 2'd2, 4'd0, 10'd0);
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.log_wr) nw++;
        end
        chk("t3_no_retrig_wr", nw, 0);
        chk("t3_no_retrig_busy", {31'b0, bus.busy}, 32'd1);
        bus.ext_trig = 0;
        tick(); tick(); tick();
        #2 bus.ext_trig = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t3_re%0d", k), {31'b0, bus.log_wr}, {31'b0, k == 4});
        end
        tick();
        chk("t3_done2", {31'b0, bus.done}, 32'd1);
        bus.ext_trig = 0; bus.s0_vld = 0;

        // Full-depth capture, no 1025th write
        arm_cfg(1'b0, 2'd0, 4'd0, 10'd1023);
        tick(); tick();
        nw = 0; bad = 0;
        for (int i = 0; i < 1040; i++) begin
            bus.s0_vld = 1; bus.s0_iq = 16'(i);
            tick();
            if (bus.log_wr) begin
                if (bus.log_din !== 16'(nw)) bad++;
                nw++;
            end
        end
        chk("t4_writes", nw, 1024);
        chk("t4_data_errs", bad, 0);
        chk("t4_wc", {21'b0, bus.word_cnt}, 32'd1024);
        chk("t4_done", {31'b0, bus.done}, 32'd1);
        bus.s0_vld = 0;

        // Abort at word 5 coincident with a valid; arm while busy ignored
        arm_cfg(1'b0, 2'd0, 4'd0, 10'd15);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            bus.s0_vld = 1; bus.s0_iq = 16'h3000 + 16'(i);
            if (i == 2) begin bus.cmd_arm = 1; bus.cfg_len = 10'd0; end
            tick();
            bus.cmd_arm = 0;
            chk($sformatf("t5_wr%0d", i), {30'b0, bus.log_rst, bus.log_wr}, 32'd1);
        end
        bus.s0_iq = 16'h3005; bus.cmd_abort = 1;
        tick();
        bus.cmd_abort = 0;
        chk("t5_abort", {19'b0, bus.log_wr, bus.busy, bus.done, bus.word_cnt},
            {19'b0, 1'b0, 1'b0, 1'b0, 11'd5});
        tick();
        chk("t5_idle", {30'b0, bus.log_wr, bus.busy}, 32'd0);
        bus.s0_vld = 0;

        // Async reset mid-capture
        arm_cfg(1'b0, 2'd0, 4'd0, 10'd15);
        tick(); tick();
        bus.s0_vld = 1; bus.s0_iq = 16'h4000;
        tick();
        chk("t6_prewr", {31'b0, bus.log_wr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rst", obs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_after", obs(), 32'h0);
        bus.s0_vld = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
